// File: rtl/mc_ctrl_hs_if.sv
// rtl/mc_ctrl_hs_if.sv - control/handshake bus between mc_ctrl_hs and the datapath/memories
//
// Groups the instruction/flag inputs, both memory req/ack handshakes and the
// datapath control strobes.
//   master : controller side (drives requests and strobes)
//   slave  : datapath/memory side (drives instr, compare and acks)
interface mc_ctrl_hs_if;
  logic [31:0] instr;
  logic [2:0]  compare;
  logic        imem_req;
  logic        imem_ack;
  logic        dmem_req;
  logic        dmem_ack;
  logic        pc_wr;
  logic        ir_wr;
  logic        reg_we;
  logic        mem_we;
  logic        alu_src;
  logic        br_valid;
  logic [1:0]  reg_dst;
  logic [1:0]  mem_to_reg;
  logic [1:0]  ext_op;
  logic [2:0]  jump;
  logic [3:0]  alu_op;

  modport master (
    input  instr, compare, imem_ack, dmem_ack,
    output imem_req, dmem_req, pc_wr, ir_wr, reg_we, mem_we, alu_src,
           br_valid, reg_dst, mem_to_reg, ext_op, jump, alu_op
  );

  modport slave (
    output instr, compare, imem_ack, dmem_ack,
    input  imem_req, dmem_req, pc_wr, ir_wr, reg_we, mem_we, alu_src,
           br_valid, reg_dst, mem_to_reg, ext_op, jump, alu_op
  );
endinterface

// File: rtl/mc_ctrl_hs.sv
// rtl/mc_ctrl_hs.sv - handshaking multicycle MIPS control unit
//
// Sequences each instruction through IF/ID/EX/MA/WB, waiting on req/ack
// handshakes to the instruction and data memories, and drives the datapath
// control strobes combinationally from state, instr, compare and ack.
//   clk       : system clock, rising edge
//   rst       : asynchronous active-low reset
//   bus       : mc_ctrl_hs_if.master (instr/compare in, acks in, reqs and strobes out)
//   instr_cnt : retired-instruction counter, wraps modulo 2^CNT_W
//   trap      : sticky trap flag
// Optional feature macro MC_TRAP_EN: unsupported instructions and bus
// timeouts (TIMEOUT_CYC wait cycles) go to a terminal trap state. Without it
// unsupported instructions retire as NOPs and requests wait indefinitely.
module mc_ctrl_hs #(
  parameter int TIMEOUT_CYC = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  mc_ctrl_hs_if.master     bus,
  output logic [CNT_W-1:0] instr_cnt,
  output logic             trap
);

  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_ID   = 3'd1,
    S_EX   = 3'd2,
    S_MA   = 3'd3,
    S_WB   = 3'd4,
    S_TRAP = 3'd5
  } state_t;

  state_t state, next_state;

  logic [5:0] op, funct;
  assign op    = bus.instr[31:26];
  assign funct = bus.instr[5:0];

  logic unused_bits;
  assign unused_bits = ^{bus.instr[25:6], bus.compare[2:1]};

  logic is_r, i_addu, i_subu, i_and, i_or, i_slt, i_jr;
  logic i_addiu, i_ori, i_lui, i_lw, i_sw, i_beq, i_bne, i_j, i_jal;
  logic is_alu_r, is_imm, is_br, is_mem, supported;

  assign is_r    = (op == 6'h00);
  assign i_addu  = is_r && (funct == 6'h21);
  assign i_subu  = is_r && (funct == 6'h23);
  assign i_and   = is_r && (funct == 6'h24);
  assign i_or    = is_r && (funct == 6'h25);
  assign i_slt   = is_r && (funct == 6'h2A);
  assign i_jr    = is_r && (funct == 6'h08);
  assign i_addiu = (op == 6'h09);
  assign i_ori   = (op == 6'h0D);
  assign i_lui   = (op == 6'h0F);
  assign i_lw    = (op == 6'h23);
  assign i_sw    = (op == 6'h2B);
  assign i_beq   = (op == 6'h04);
  assign i_bne   = (op == 6'h05);
  assign i_j     = (op == 6'h02);
  assign i_jal   = (op == 6'h03);

  assign is_alu_r  = i_addu || i_subu || i_and || i_or || i_slt;
  assign is_imm    = i_addiu || i_ori || i_lui || i_lw || i_sw;
  assign is_br     = i_beq || i_bne;
  assign is_mem    = i_lw || i_sw;
  assign supported = is_alu_r || i_jr || is_imm || is_br || i_j || i_jal;

  // An ack only counts while its request is actually outstanding.
  logic imem_go, dmem_go;
  assign imem_go = bus.imem_req && bus.imem_ack;
  assign dmem_go = bus.dmem_req && bus.dmem_ack;

  logic bus_err;

`ifdef MC_TRAP_EN
  localparam int WCW = $clog2(TIMEOUT_CYC + 1);
  logic [WCW-1:0] wait_cnt;
  logic           waiting;

  assign waiting = (state == S_IF && bus.imem_req && !bus.imem_ack) ||
                   (state == S_MA && bus.dmem_req && !bus.dmem_ack);
  // Error only when the limit is reached and no ack shows up in that cycle.
  assign bus_err = waiting && (wait_cnt == WCW'(TIMEOUT_CYC));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt <= '0;
    end else if (imem_go || dmem_go ||
                 (next_state != state && (next_state == S_IF || next_state == S_MA))) begin
      wait_cnt <= '0;
    end else if (waiting && wait_cnt != WCW'(TIMEOUT_CYC)) begin
      wait_cnt <= wait_cnt + WCW'(1);
    end
  end

  assign trap = (state == S_TRAP);
`else
  localparam int unused_timeout = TIMEOUT_CYC;
  assign bus_err = 1'b0;
  assign trap    = 1'b0;
`endif

  // State register, request registers and retirement counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= S_IF;
      bus.imem_req <= 1'b0;
      bus.dmem_req <= 1'b0;
      instr_cnt    <= '0;
    end else begin
      state        <= next_state;
      bus.imem_req <= (next_state == S_IF);
      bus.dmem_req <= (next_state == S_MA);
      if (state != S_IF && next_state == S_IF)
        instr_cnt <= instr_cnt + CNT_W'(1);
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IF: begin
        if (imem_go)      next_state = S_ID;
        else if (bus_err) next_state = S_TRAP;
      end
      S_ID: begin
        if (i_jal)              next_state = S_WB;
        else if (i_j || i_jr)   next_state = S_IF;
        else if (supported)     next_state = S_EX;
        else begin
`ifdef MC_TRAP_EN
          next_state = S_TRAP;
`else
          next_state = S_IF;
`endif
        end
      end
      S_EX: begin
        if (is_br)       next_state = S_IF;
        else if (is_mem) next_state = S_MA;
        else             next_state = S_WB;
      end
      S_MA: begin
        if (dmem_go)      next_state = i_sw ? S_IF : S_WB;
        else if (bus_err) next_state = S_TRAP;
      end
      S_WB:    next_state = S_IF;
      S_TRAP:  next_state = S_TRAP;
      default: next_state = S_IF;
    endcase
  end

  always_comb begin
    bus.pc_wr      = 1'b0;
    bus.ir_wr      = 1'b0;
    bus.reg_we     = 1'b0;
    bus.mem_we     = 1'b0;
    bus.alu_src    = 1'b0;
    bus.br_valid   = 1'b0;
    bus.reg_dst    = 2'b00;
    bus.mem_to_reg = 2'b00;
    bus.ext_op     = 2'b00;
    bus.jump       = 3'b000;
    bus.alu_op     = 4'b0000;
    case (state)
      S_IF: begin
        if (imem_go) begin
          bus.ir_wr = 1'b1;
          bus.pc_wr = 1'b1;
        end
      end
      S_ID: begin
        if (i_j || i_jal) begin
          bus.pc_wr = 1'b1;
          bus.jump  = 3'b001;
        end else if (i_jr) begin
          bus.pc_wr = 1'b1;
          bus.jump  = 3'b010;
        end
      end
      S_EX: begin
        bus.alu_src = is_imm;
        if (i_addiu || is_mem) bus.ext_op = 2'b01;
        else if (i_lui)        bus.ext_op = 2'b10;
        if (i_subu || is_br)      bus.alu_op = 4'b0001;
        else if (i_and)           bus.alu_op = 4'b0010;
        else if (i_or || i_ori)   bus.alu_op = 4'b0011;
        else if (i_slt)           bus.alu_op = 4'b0100;
        else if (i_lui)           bus.alu_op = 4'b0101;
        if (is_br) begin
          bus.br_valid = 1'b1;
          bus.jump     = 3'b011;
          bus.pc_wr    = i_beq ? bus.compare[0] : ~bus.compare[0];
        end
      end
      S_MA: begin
        bus.mem_we = i_sw;
      end
      S_WB: begin
        bus.reg_we = 1'b1;
        if (i_jal) begin
          bus.reg_dst    = 2'b10;
          bus.mem_to_reg = 2'b10;
        end else if (is_r) begin
          bus.reg_dst = 2'b01;
        end else if (i_lw) begin
          bus.mem_to_reg = 2'b01;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mc_ctrl_hs.sv
// tb/tb_mc_ctrl_hs.sv - directed self-checking bench for mc_ctrl_hs
module tb_mc_ctrl_hs;
  localparam int CNT_W = 4;
  localparam int TO    = 16;

  localparam logic [31:0] I_ADDU  = {6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h21};
  localparam logic [31:0] I_SUBU  = {6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h23};
  localparam logic [31:0] I_JR    = {6'h00, 5'd31, 5'd0, 5'd0, 5'd0, 6'h08};
  localparam logic [31:0] I_ADDIU = {6'h09, 5'd1, 5'd2, 16'h8000};
  localparam logic [31:0] I_ORI   = {6'h0D, 5'd1, 5'd2, 16'hFFFF};
  localparam logic [31:0] I_LUI   = {6'h0F, 5'd0, 5'd2, 16'h1234};
  localparam logic [31:0] I_LW    = {6'h23, 5'd1, 5'd2, 16'h0004};
  localparam logic [31:0] I_SW    = {6'h2B, 5'd1, 5'd2, 16'h0004};
  localparam logic [31:0] I_BEQ   = {6'h04, 5'd1, 5'd2, 16'h0003};
  localparam logic [31:0] I_BNE   = {6'h05, 5'd1, 5'd2, 16'h0003};
  localparam logic [31:0] I_J     = {6'h02, 26'h0000010};
  localparam logic [31:0] I_JAL   = {6'h03, 26'h0000010};
  localparam logic [31:0] I_BAD   = {6'h3F, 26'h0000000};

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mc_ctrl_hs_if bus();
  logic [CNT_W-1:0] instr_cnt;
  logic             trap;

  mc_ctrl_hs #(.TIMEOUT_CYC(TO), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .bus(bus), .instr_cnt(instr_cnt), .trap(trap)
  );

  typedef struct packed {
    logic       imem_req, dmem_req, pc_wr, ir_wr, reg_we, mem_we, alu_src, br_valid;
    logic [1:0] reg_dst, mem_to_reg, ext_op;
    logic [2:0] jump;
    logic [3:0] alu_op;
  } snap_t;

  snap_t snap [0:63];
  int    ncyc;
  int    n_checks = 0;
  int    n_fail   = 0;
  int    model_cnt = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Runs one instruction from the start of S_IF; iw/dw are wait states before
  // each ack. Stops when the next fetch starts or after 40 cycles.
  task automatic run(input logic [31:0] ins, input int iw, input int dw, input logic [2:0] cmp);
    int icnt = 0;
    int dcnt = 0;
    bus.instr   = ins;
    bus.compare = cmp;
    ncyc = 0;
    while (ncyc < 40) begin
      bus.imem_ack = bus.imem_req && (icnt == iw);
      bus.dmem_ack = bus.dmem_req && (dcnt == dw);
      #1;
      snap[ncyc] = {bus.imem_req, bus.dmem_req, bus.pc_wr, bus.ir_wr, bus.reg_we,
                    bus.mem_we, bus.alu_src, bus.br_valid, bus.reg_dst, bus.mem_to_reg,
                    bus.ext_op, bus.jump, bus.alu_op};
      if (bus.imem_req) icnt++;
      if (bus.dmem_req) dcnt++;
      ncyc++;
      @(posedge clk);
      #1;
      if (bus.imem_req && icnt > iw) break;
    end
    bus.imem_ack = 1'b0;
    bus.dmem_ack = 1'b0;
  endtask

  task automatic retired(input string tag);
    model_cnt++;
    check(tag, 32'(instr_cnt), 32'(model_cnt % (1 << CNT_W)));
  endtask

  function automatic int count_req(input bit dside);
    int n = 0;
    for (int i = 0; i < ncyc; i++)
      n += dside ? int'(snap[i].dmem_req) : int'(snap[i].imem_req);
    return n;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  logic [31:0] br_ins [4] = '{I_BEQ, I_BEQ, I_BNE, I_BNE};
  logic [2:0]  br_cmp [4] = '{3'b001, 3'b000, 3'b001, 3'b000};
  logic        br_exp [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  initial begin
    bus.instr = 32'h0; bus.compare = 3'b000;
    bus.imem_ack = 1'b0; bus.dmem_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_imem_req", bus.imem_req, 0);
    check("rst_dmem_req", bus.dmem_req, 0);
    check("rst_instr_cnt", instr_cnt, 0);
    check("rst_trap", trap, 0);
    check("rst_pc_wr", bus.pc_wr, 0);
    check("rst_reg_we", bus.reg_we, 0);

    // Stray ack with no request outstanding must be ignored.
    @(negedge clk);
    rst = 1'b1;
    bus.instr = I_ADDU;
    bus.imem_ack = 1'b1;
    #1;
    check("noreq_imem_req", bus.imem_req, 0);
    check("noreq_ir_wr", bus.ir_wr, 0);
    @(posedge clk);
    #1;
    check("first_imem_req", bus.imem_req, 1);
    check("still_if_ir_wr", bus.ir_wr, 1);
    bus.imem_ack = 1'b0;

    run(I_ADDU, 0, 0, 3'b000);
    check("addu_lat", ncyc, 4);
    check("addu_if_ir_wr", snap[0].ir_wr, 1);
    check("addu_if_pc_wr", snap[0].pc_wr, 1);
    check("addu_if_jump", snap[0].jump, 0);
    check("addu_wb_reg_we", snap[3].reg_we, 1);
    check("addu_wb_reg_dst", snap[3].reg_dst, 2'b01);
    check("addu_wb_alu_op", snap[3].alu_op, 4'b0000);
    retired("addu_cnt");

    run(I_SUBU, 0, 0, 3'b000);
    check("subu_lat", ncyc, 4);
    check("subu_ex_alu_op", snap[2].alu_op, 4'b0001);
    check("subu_ex_alu_src", snap[2].alu_src, 0);
    retired("subu_cnt");

    run(I_LW, 3, 2, 3'b000);
    check("lw_lat", ncyc, 10);
    check("lw_imem_req_cyc", count_req(1'b0), 4);
    check("lw_dmem_req_cyc", count_req(1'b1), 3);
    check("lw_if_wait_ir_wr", snap[0].ir_wr, 0);
    check("lw_if_ack_ir_wr", snap[3].ir_wr, 1);
    check("lw_ex_ext_op", snap[5].ext_op, 2'b01);
    check("lw_ex_alu_src", snap[5].alu_src, 1);
    check("lw_ma_mem_we", snap[8].mem_we, 0);
    check("lw_wb_mem_to_reg", snap[9].mem_to_reg, 2'b01);
    check("lw_wb_reg_dst", snap[9].reg_dst, 2'b00);
    check("lw_wb_reg_we", snap[9].reg_we, 1);
    retired("lw_cnt");

    run(I_SW, 0, 1, 3'b000);
    check("sw_lat", ncyc, 5);
    check("sw_ma_mem_we0", snap[3].mem_we, 1);
    check("sw_ma_mem_we1", snap[4].mem_we, 1);
    check("sw_reg_we", snap[4].reg_we, 0);
    retired("sw_cnt");

    for (int k = 0; k < 4; k++) begin
      run(br_ins[k], 0, 0, br_cmp[k]);
      check($sformatf("br%0d_lat", k), ncyc, 3);
      check($sformatf("br%0d_pc_wr", k), snap[2].pc_wr, br_exp[k]);
      check($sformatf("br%0d_jump", k), snap[2].jump, 3'b011);
      check($sformatf("br%0d_br_valid", k), snap[2].br_valid, 1);
      retired($sformatf("br%0d_cnt", k));
    end

    run(I_JAL, 0, 0, 3'b000);
    check("jal_lat", ncyc, 3);
    check("jal_id_pc_wr", snap[1].pc_wr, 1);
    check("jal_id_jump", snap[1].jump, 3'b001);
    check("jal_wb_reg_dst", snap[2].reg_dst, 2'b10);
    check("jal_wb_mem_to_reg", snap[2].mem_to_reg, 2'b10);
    check("jal_wb_reg_we", snap[2].reg_we, 1);
    retired("jal_cnt");

    run(I_J, 0, 0, 3'b000);
    check("j_lat", ncyc, 2);
    check("j_id_jump", snap[1].jump, 3'b001);
    check("j_id_pc_wr", snap[1].pc_wr, 1);
    retired("j_cnt");

    run(I_JR, 0, 0, 3'b000);
    check("jr_lat", ncyc, 2);
    check("jr_id_jump", snap[1].jump, 3'b010);
    retired("jr_cnt");

    run(I_ORI, 0, 0, 3'b000);
    check("ori_ext_op", snap[2].ext_op, 2'b00);
    check("ori_alu_src", snap[2].alu_src, 1);
    check("ori_alu_op", snap[2].alu_op, 4'b0011);
    check("ori_wb_reg_dst", snap[3].reg_dst, 2'b00);
    retired("ori_cnt");

    run(I_LUI, 0, 0, 3'b000);
    check("lui_ext_op", snap[2].ext_op, 2'b10);
    check("lui_alu_op", snap[2].alu_op, 4'b0101);
    retired("lui_cnt");

    run(I_ADDIU, 0, 0, 3'b000);
    check("addiu_ext_op", snap[2].ext_op, 2'b01);
    check("addiu_alu_op", snap[2].alu_op, 4'b0000);
    retired("addiu_cnt");

`ifndef MC_TRAP_EN
    run(I_BAD, 0, 0, 3'b000);
    check("bad_nop_lat", ncyc, 2);
    check("bad_nop_pc_wr", snap[1].pc_wr, 0);
    retired("bad_nop_cnt");
`endif

    do begin
      run(I_J, 0, 0, 3'b000);
      retired("wrap_j_cnt");
    end while (model_cnt % (1 << CNT_W) != 0);
    check("cnt_wrap_zero", instr_cnt, 0);

    // Reset asserted while the data request is outstanding.
    bus.instr = I_LW;
    bus.imem_ack = 1'b1;
    @(posedge clk); #1;
    bus.imem_ack = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("ma_dmem_req", bus.dmem_req, 1);
    rst = 1'b0;
    #1;
    check("ma_rst_dmem_req", bus.dmem_req, 0);
    check("ma_rst_imem_req", bus.imem_req, 0);
    check("ma_rst_reg_we", bus.reg_we, 0);
    check("ma_rst_cnt", instr_cnt, 0);
    @(negedge clk);
    rst = 1'b1;
    model_cnt = 0;
    @(posedge clk); #1;
    check("ma_rst_back_if", bus.imem_req, 1);
    run(I_J, 0, 0, 3'b000);
    retired("post_rst_cnt");

    // Long fetch wait: ack arrives on the cycle the wait counter reaches TO.
    bus.instr = I_J;
    bus.imem_ack = 1'b0;
    repeat (TO) @(posedge clk);
    #1;
    check("to_edge_trap", trap, 0);
    check("to_edge_imem_req", bus.imem_req, 1);
    bus.imem_ack = 1'b1;
    #1;
    check("to_edge_ack_ir_wr", bus.ir_wr, 1);
    @(posedge clk); #1;
    bus.imem_ack = 1'b0;
    @(posedge clk); #1;
    retired("to_edge_cnt");

`ifdef MC_TRAP_EN
    repeat (TO + 1) @(posedge clk);
    #1;
    check("to_trap", trap, 1);
    check("to_trap_imem_req", bus.imem_req, 0);
    check("to_trap_cnt", instr_cnt, 32'(model_cnt % (1 << CNT_W)));
    bus.imem_ack = 1'b1;
    #1;
    check("to_trap_ir_wr", bus.ir_wr, 0);
    bus.imem_ack = 1'b0;

    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    model_cnt = 0;
    @(posedge clk); #1;
    run(I_BAD, 0, 0, 3'b000);
    check("bad_no_return", ncyc, 40);
    check("bad_trap", trap, 1);
    check("bad_cnt", instr_cnt, 0);
    check("bad_id_pc_wr", snap[1].pc_wr, 0);
    check("bad_imem_req", snap[39].imem_req, 0);
`else
    repeat (3 * TO) @(posedge clk);
    #1;
    check("nto_trap", trap, 0);
    check("nto_imem_req", bus.imem_req, 1);
    run(I_J, 0, 0, 3'b000);
    check("nto_lat", ncyc, 2);
    retired("nto_cnt");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
